// File: rtl/red_iter.sv
// Iterative lane-sum reducer: adds one rs/rt lane pair per cycle and returns the widened total in rd.
// Optional RED_SKID_EN adds a one-entry request buffer so a start can be taken while a sum is in progress.
module red_iter #(
    parameter int WIDTH = 16,
    parameter int LANE  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             mode,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] rd
);
    localparam int N    = WIDTH / LANE;
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;
    localparam int ACCW = LANE + 1 + $clog2(N);

    generate
        if ((WIDTH % LANE) != 0 || N < 2 || ACCW > WIDTH) begin : g_bad_cfg
            $error("red_iter: illegal WIDTH/LANE combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rs_q, rs_d, rt_q, rt_d;
    logic             mode_q, mode_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [ACCW-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0] rd_q, rd_d;

    logic             accept, launch, last;
    logic [WIDTH-1:0] launch_rs, launch_rt;
    logic             launch_mode;
    logic [ACCW-1:0]  pair_sum [N];
    logic [ACCW-1:0]  acc_sum;

`ifdef RED_SKID_EN
    logic [WIDTH-1:0] buf_rs_q, buf_rs_d, buf_rt_q, buf_rt_d;
    logic             buf_mode_q, buf_mode_d, buf_valid_q, buf_valid_d;
`endif

    function automatic logic [ACCW-1:0] ext_lane(input logic [LANE-1:0] v, input logic sgn);
        return sgn ? ACCW'($signed(v)) : ACCW'(v);
    endfunction

    // Every lane pair is pre-summed; the counter only selects which one joins the accumulator.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pair
            assign pair_sum[gi] = ext_lane(rs_q[gi*LANE +: LANE], mode_q)
                                + ext_lane(rt_q[gi*LANE +: LANE], mode_q);
        end
    endgenerate

    assign acc_sum = acc_q + pair_sum[cnt_q];
    assign last    = (cnt_q == CNTW'(N - 1));
    assign accept  = start && ready;
    assign rd      = rd_q;

    always_comb begin
        launch      = 1'b0;
        launch_rs   = rs;
        launch_rt   = rt;
        launch_mode = mode;
        case (state_q)
            IDLE: launch = accept;
            DONE: begin
`ifdef RED_SKID_EN
                if (buf_valid_q) begin
                    launch      = 1'b1;
                    launch_rs   = buf_rs_q;
                    launch_rt   = buf_rt_q;
                    launch_mode = buf_mode_q;
                end else begin
                    launch = accept;
                end
`else
                launch = accept;
`endif
            end
            default: launch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = launch ? ACC : IDLE;
            ACC:     state_d = last ? DONE : ACC;
            DONE:    state_d = launch ? ACC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef RED_SKID_EN
        ready = !buf_valid_q;
`else
        ready = (state_q != ACC);
`endif
        done = (state_q == DONE);
    end

    always_comb begin
        rs_d   = rs_q;
        rt_d   = rt_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        rd_d   = rd_q;
        if (launch) begin
            rs_d   = launch_rs;
            rt_d   = launch_rt;
            mode_d = launch_mode;
            cnt_d  = '0;
            acc_d  = '0;
        end else if (state_q == ACC) begin
            acc_d = acc_sum;
            cnt_d = last ? '0 : cnt_q + CNTW'(1);
            if (last) rd_d = mode_q ? WIDTH'($signed(acc_sum)) : WIDTH'(acc_sum);
        end
    end

`ifdef RED_SKID_EN
    always_comb begin
        buf_rs_d    = buf_rs_q;
        buf_rt_d    = buf_rt_q;
        buf_mode_d  = buf_mode_q;
        buf_valid_d = buf_valid_q;
        if (state_q == ACC && accept) begin
            buf_rs_d    = rs;
            buf_rt_d    = rt;
            buf_mode_d  = mode;
            buf_valid_d = 1'b1;
        end else if (state_q == DONE && buf_valid_q) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_rs_q    <= '0;
            buf_rt_q    <= '0;
            buf_mode_q  <= 1'b0;
            buf_valid_q <= 1'b0;
        end else begin
            buf_rs_q    <= buf_rs_d;
            buf_rt_q    <= buf_rt_d;
            buf_mode_q  <= buf_mode_d;
            buf_valid_q <= buf_valid_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q   <= '0;
            rt_q   <= '0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            rd_q   <= '0;
        end else begin
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            rd_q   <= rd_d;
        end
    end

endmodule
